// File: rtl/mem_sram_bridge_pkg.sv
// Shared types and constants for the native-memory-port to SRAM bridge.
// Also carries the request classifier used when a request is accepted.
package mem_sram_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StData,
    StWait,
    StResp,
    StErr
  } state_e;

  localparam logic [3:0]  WSTRB_READ = 4'b0000;
  localparam logic [31:0] ERR_RDATA  = 32'h0;
  localparam int unsigned WAIT_W     = 4;

  // offset is (addr - base) modulo 2^32; base is word aligned so offset[1:0] == addr[1:0]
  function automatic logic req_is_error(input logic [31:0] offset,
                                        input logic [32:0] span,
                                        input logic        instr,
                                        input logic [3:0]  wstrb);
    return ({1'b0, offset} >= span) || (offset[1:0] != 2'b00) ||
           (instr && (wstrb != WSTRB_READ));
  endfunction

endpackage

// File: rtl/mem_sram_bridge_perf.sv
// Free-running response counters for the bridge; cleared by the synchronous active-low reset.
// Only instantiated when MEM_SRAM_BRIDGE_PERF_EN is defined.
module mem_sram_bridge_perf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_i,
  input  logic        data_i,
  input  logic        err_i,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_data_o,
  output logic [31:0] perf_err_o
);

  logic [31:0] fetch_q, fetch_d;
  logic [31:0] data_q, data_d;
  logic [31:0] err_q, err_d;

  always_comb begin
    fetch_d = fetch_q + {31'b0, fetch_i};
    data_d  = data_q + {31'b0, data_i};
    err_d   = err_q + {31'b0, err_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      fetch_q <= fetch_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign perf_fetch_o = fetch_q;
  assign perf_data_o  = data_q;
  assign perf_err_o   = err_q;

endmodule

// File: rtl/mem_sram_bridge.sv
// Native memory port slave driving a single-port synchronous SRAM (1-cycle read latency).
// Define MEM_SRAM_BRIDGE_PERF_EN to add the perf_fetch/perf_data/perf_err counter outputs.
module mem_sram_bridge
  import mem_sram_bridge_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned AW         = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid,
  input  logic          mem_instr,
  output logic          mem_ready,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_rdata,
  output logic          bus_error,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
`ifdef MEM_SRAM_BRIDGE_PERF_EN
  ,
  output logic [31:0]   perf_fetch,
  output logic [31:0]   perf_data,
  output logic [31:0]   perf_err
`endif
);

  localparam logic [32:0]       MemSpan  = 33'(MEM_WORDS) << 2;
  localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                mem_ready_q, mem_ready_d;
  logic                bus_error_q, bus_error_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                sram_en_q, sram_en_d;
  logic [3:0]          sram_we_q, sram_we_d;
  logic [AW-1:0]       sram_addr_q, sram_addr_d;
  logic [31:0]         sram_wdata_q, sram_wdata_d;
`ifdef MEM_SRAM_BRIDGE_PERF_EN
  logic                instr_q, instr_d;
`endif

  logic [31:0] addr_off;
  assign addr_off = mem_addr - BASE_ADDR;

  // Outputs are registered: each is loaded on the transition into the state that owns it.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    mem_ready_d  = 1'b0;
    bus_error_d  = 1'b0;
    mem_rdata_d  = ERR_RDATA;
    sram_en_d    = 1'b0;
    sram_we_d    = WSTRB_READ;
`ifdef MEM_SRAM_BRIDGE_PERF_EN
    instr_d      = instr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          wstrb_d = mem_wstrb;
`ifdef MEM_SRAM_BRIDGE_PERF_EN
          instr_d = mem_instr;
`endif
          if (req_is_error(addr_off, MemSpan, mem_instr, mem_wstrb)) begin
            state_d     = StErr;
            mem_ready_d = 1'b1;
            bus_error_d = 1'b1;
          end else begin
            state_d      = StIssue;
            sram_en_d    = 1'b1;
            sram_we_d    = mem_wstrb;
            sram_addr_d  = addr_off[AW+1:2];
            sram_wdata_d = mem_wdata;
          end
        end
      end
      StIssue: begin
        state_d = StData;
      end
      StData: begin
        rdata_d = (wstrb_q == WSTRB_READ) ? sram_rdata : '0;
        if (WAIT_STATES == 0) begin
          state_d     = StResp;
          mem_ready_d = 1'b1;
          mem_rdata_d = rdata_d;
        end else begin
          state_d    = StWait;
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          state_d     = StResp;
          mem_ready_d = 1'b1;
          mem_rdata_d = rdata_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StResp, StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      mem_ready_q  <= 1'b0;
      bus_error_q  <= 1'b0;
      mem_rdata_q  <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
`ifdef MEM_SRAM_BRIDGE_PERF_EN
      instr_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      mem_ready_q  <= mem_ready_d;
      bus_error_q  <= bus_error_d;
      mem_rdata_q  <= mem_rdata_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
`ifdef MEM_SRAM_BRIDGE_PERF_EN
      instr_q      <= instr_d;
`endif
    end
  end

  assign mem_ready  = mem_ready_q;
  assign bus_error  = bus_error_q;
  assign mem_rdata  = mem_rdata_q;
  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

`ifdef MEM_SRAM_BRIDGE_PERF_EN
  logic resp_fetch, resp_data;
  assign resp_fetch = mem_ready_q & ~bus_error_q & instr_q;
  assign resp_data  = mem_ready_q & ~bus_error_q & ~instr_q;

  mem_sram_bridge_perf u_perf (
    .clk_i        (clk),
    .rst_ni       (reset),
    .fetch_i      (resp_fetch),
    .data_i       (resp_data),
    .err_i        (bus_error_q),
    .perf_fetch_o (perf_fetch),
    .perf_data_o  (perf_data),
    .perf_err_o   (perf_err)
  );
`endif

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Bench for mem_sram_bridge: two instances (0 and 2 wait states) share one core driver and are
// checked every cycle against a cycle-scheduled response model, plus directed literal checks.
module tb_mem_sram_bridge;

  localparam int MW = 1024;
  localparam int NC = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;

  logic        rdy [2];
  logic        berr[2];
  logic [31:0] rdata[2];
  logic        en  [2];
  logic [3:0]  we  [2];
  logic [9:0]  saddr[2];
  logic [31:0] swd [2];
  logic [31:0] srd [2];
`ifdef MEM_SRAM_BRIDGE_PERF_EN
  logic [31:0] pf[2], pd[2], pe[2];
`endif

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_sram_bridge #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(rdy[0]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(rdata[0]),
    .bus_error(berr[0]), .sram_en(en[0]), .sram_we(we[0]), .sram_addr(saddr[0]),
    .sram_wdata(swd[0]), .sram_rdata(srd[0])
`ifdef MEM_SRAM_BRIDGE_PERF_EN
    , .perf_fetch(pf[0]), .perf_data(pd[0]), .perf_err(pe[0])
`endif
  );

  mem_sram_bridge #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(rdy[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(rdata[1]),
    .bus_error(berr[1]), .sram_en(en[1]), .sram_we(we[1]), .sram_addr(saddr[1]),
    .sram_wdata(swd[1]), .sram_rdata(srd[1])
`ifdef MEM_SRAM_BRIDGE_PERF_EN
    , .perf_fetch(pf[1]), .perf_data(pd[1]), .perf_err(pe[1])
`endif
  );

  // SRAM devices behind each instance
  logic [31:0] sram0[MW];
  logic [31:0] sram2[MW];

  always @(posedge clk) begin
    if (en[0]) begin
      for (int b = 0; b < 4; b++) if (we[0][b]) sram0[saddr[0]][8*b +: 8] <= swd[0][8*b +: 8];
      if (we[0] == 4'b0) srd[0] <= sram0[saddr[0]];
    end
    if (en[1]) begin
      for (int b = 0; b < 4; b++) if (we[1][b]) sram2[saddr[1]][8*b +: 8] <= swd[1][8*b +: 8];
      if (we[1] == 4'b0) srd[1] <= sram2[saddr[1]];
    end
  end

  // Reference model: on acceptance, schedule the expected outputs at absolute cycle numbers.
  typedef struct packed {
    logic        rdy;
    logic        err;
    logic [31:0] rd;
    logic        en;
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        f;
  } exp_t;

  exp_t        exq [2][NC];
  logic [31:0] mmem[2][MW];
  int          idle_at[2];
  logic [31:0] perf_m[2][3];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int   ws = (i == 0) ? 0 : 2;
      automatic exp_t e  = exq[i][cyc];
      if (chk_en) begin
        checks++;
        if ({rdy[i], berr[i], rdata[i], en[i], we[i]} !== {e.rdy, e.err, e.rd, e.en, e.we}) begin
          errors++;
          $display("FAIL port[%0d] cyc=%0d got rdy=%b err=%b rdata=%h en=%b we=%b want rdy=%b err=%b rdata=%h en=%b we=%b",
                   i, cyc, rdy[i], berr[i], rdata[i], en[i], we[i], e.rdy, e.err, e.rd, e.en, e.we);
        end
        if (e.en) begin
          checks++;
          if ({saddr[i], swd[i]} !== {e.addr, e.wd}) begin
            errors++;
            $display("FAIL sram[%0d] cyc=%0d got addr=%h wdata=%h want addr=%h wdata=%h",
                     i, cyc, saddr[i], swd[i], e.addr, e.wd);
          end
        end
`ifdef MEM_SRAM_BRIDGE_PERF_EN
        checks++;
        if ({pf[i], pd[i], pe[i]} !== {perf_m[i][0], perf_m[i][1], perf_m[i][2]}) begin
          errors++;
          $display("FAIL perf[%0d] cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d", i, cyc,
                   pf[i], pd[i], pe[i], perf_m[i][0], perf_m[i][1], perf_m[i][2]);
        end
`endif
      end
      if (e.rdy) begin
        if (e.err) perf_m[i][2]++;
        else if (e.f) perf_m[i][0]++;
        else perf_m[i][1]++;
      end
      if (!reset) begin
        for (int k = 1; k <= 20; k++) exq[i][cyc+k] = '0;
        for (int k = 0; k < 3; k++) perf_m[i][k] = '0;
        idle_at[i] = cyc + 1;
      end else if (mem_valid && cyc >= idle_at[i]) begin
        automatic logic [31:0] off = mem_addr - 32'h0;
        automatic logic [31:0] rd  = '0;
        automatic logic [9:0]  wi  = off[11:2];
        if (off >= 32'd4096 || mem_addr[1:0] != 2'b00 || (mem_instr && mem_wstrb != 4'b0)) begin
          exq[i][cyc+1].rdy = 1'b1;
          exq[i][cyc+1].err = 1'b1;
          exq[i][cyc+1].f   = mem_instr;
          idle_at[i] = cyc + 2;
        end else begin
          exq[i][cyc+1].en   = 1'b1;
          exq[i][cyc+1].we   = mem_wstrb;
          exq[i][cyc+1].addr = wi;
          exq[i][cyc+1].wd   = mem_wdata;
          if (mem_wstrb == 4'b0) rd = mmem[i][wi];
          else for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mmem[i][wi][8*b +: 8] = mem_wdata[8*b +: 8];
          exq[i][cyc+3+ws].rdy = 1'b1;
          exq[i][cyc+3+ws].rd  = rd;
          exq[i][cyc+3+ws].f   = mem_instr;
          idle_at[i] = cyc + 4 + ws;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  int          lat0, lat2, en2n;
  logic [31:0] rd0, rd2;
  logic        er0, er2;

  // Call at posedge+1; holds mem_valid until the 2-wait-state instance responds.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic ins);
    int start;
    bit g0, g2;
    if (cyc > NC - 100) begin
      $display("FAIL cycle_budget: got cyc=%0d want below %0d", cyc, NC - 100);
      $fatal(1, "cycle budget exhausted");
    end
    mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins; mem_valid = 1'b1;
    start = cyc; g0 = 0; g2 = 0; lat0 = -1; lat2 = -1; rd0 = '0; rd2 = '0; er0 = 0; er2 = 0;
    en2n = 0;
    for (int k = 0; k < 40 && !g2; k++) begin
      @(negedge clk);
      if (en[1]) en2n++;
      if (!g0 && rdy[0]) begin g0 = 1; lat0 = cyc - start; rd0 = rdata[0]; er0 = berr[0]; end
      if (!g2 && rdy[1]) begin g2 = 1; lat2 = cyc - start; rd2 = rdata[1]; er2 = berr[1]; end
      @(posedge clk); #1;
    end
    mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    if (!g2) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h: got no mem_ready want one within 40 cycles", a);
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic expect_ok(input string name, input logic [31:0] want_rd);
    chk({name, "_lat0"}, 64'(lat0), 64'd3);
    chk({name, "_lat2"}, 64'(lat2), 64'd5);
    chk({name, "_rd0"}, {31'b0, er0, rd0}, {32'b0, want_rd});
    chk({name, "_rd2"}, {31'b0, er2, rd2}, {32'b0, want_rd});
    chk({name, "_en2"}, 64'(en2n), 64'd1);
  endtask

  task automatic expect_err(input string name);
    chk({name, "_lat"}, {32'(lat0), 32'(lat2)}, {32'd1, 32'd1});
    chk({name, "_err"}, {62'b0, er0, er2}, 64'd3);
    chk({name, "_rd"}, {rd0, rd2}, 64'd0);
    chk({name, "_en2"}, 64'(en2n), 64'd0);
  endtask

  int pulses, adj, first_p, last_p, t0;
  bit prev;

  initial begin
    for (int i = 0; i < MW; i++) begin
      sram0[i] = '0; sram2[i] = '0; mmem[0][i] = '0; mmem[1][i] = '0;
    end
    for (int i = 0; i < NC; i++) begin exq[0][i] = '0; exq[1][i] = '0; end
    for (int k = 0; k < 3; k++) begin perf_m[0][k] = '0; perf_m[1][k] = '0; end
    srd[0] = '0; srd[1] = '0;
    idle_at[0] = 0; idle_at[1] = 0;

    repeat (3) @(posedge clk);
    #1; chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_hs", {57'b0, rdy[i], berr[i], en[i], we[i]}, 64'd0);
      chk("reset_data", {rdata[i], swd[i]}, 64'd0);
      chk("reset_saddr", 64'(saddr[i]), 64'd0);
    end
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read back
    do_req(32'h10, 32'hDEADBEEF, 4'hF, 1'b0); expect_ok("wr10", 32'h0);
    do_req(32'h10, 32'h0, 4'h0, 1'b0);        expect_ok("rd10", 32'hDEADBEEF);
    // Byte-lane merge
    do_req(32'h20, 32'h11223344, 4'hF, 1'b0); expect_ok("wr20", 32'h0);
    do_req(32'h20, 32'h0000AB00, 4'b0010, 1'b0); expect_ok("wb20", 32'h0);
    do_req(32'h20, 32'h0, 4'h0, 1'b0);        expect_ok("rd20", 32'h1122AB44);
    // Range / alignment / illegal-fetch errors
    do_req(32'h1000, 32'h0, 4'h0, 1'b0);      expect_err("oor");
    do_req(32'h3, 32'h0, 4'h0, 1'b0);         expect_err("misal");
    do_req(32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0); expect_err("below");
    do_req(32'h10, 32'h0, 4'hF, 1'b1);        expect_err("ifetchwr");
    // Last legal word and a legal fetch
    do_req(32'hFFC, 32'hCAFEF00D, 4'hF, 1'b0); expect_ok("wrtop", 32'h0);
    do_req(32'hFFC, 32'h0, 4'h0, 1'b1);       expect_ok("fetchtop", 32'hCAFEF00D);

    // Reset during DATA of a read, with the request already dropped
    mem_addr = 32'h20; mem_wstrb = 4'h0; mem_valid = 1'b1;
    @(posedge clk); #1; mem_valid = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_mid_hs", {57'b0, rdy[i], berr[i], en[i], we[i]}, 64'd0);
      chk("rst_mid_data", {rdata[i], swd[i]}, 64'd0);
      chk("rst_mid_saddr", 64'(saddr[i]), 64'd0);
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pulses += int'(rdy[0]) + int'(rdy[1]);
    end
    chk("rst_no_ready", 64'(pulses), 64'd0);
    @(posedge clk); #1;
    do_req(32'h20, 32'h0, 4'h0, 1'b0);        expect_ok("rd_after_rst", 32'h1122AB44);

    // mem_valid held across three back-to-back reads (fixed 18-cycle window)
    mem_addr = 32'h10; mem_wstrb = 4'h0; mem_valid = 1'b1;
    t0 = cyc; pulses = 0; adj = 0; prev = 1'b0; first_p = -1; last_p = -1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (rdy[1]) begin
        pulses++;
        if (first_p < 0) first_p = cyc - t0;
        last_p = cyc - t0;
        if (prev) adj++;
      end
      prev = rdy[1];
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
    chk("b2b_pulses", 64'(pulses), 64'd3);
    chk("b2b_adjacent", 64'(adj), 64'd0);
    chk("b2b_timing", {32'(first_p), 32'(last_p)}, {32'd5, 32'd17});
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
